pipeline_stage_regs: RTL and testbench
======================================

// Module: pipeline_stage_regs
// PURPOSE
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage pipelined CPU. It consumes the hazard
//  unit's enable/flush outputs and drives the hazard unit's inputs from the latched stage fields.
//  It also holds a sticky halt latch and a retired-instruction counter used for the CPU halt output and for testbench checks.
// PARAMETERS
//  DATA_W   96   width of opaque datapath payload per stage past ID (rdat1/rdat2/imm or ALU result/store data)
//  CTRL_W   8    width of opaque control payload per stage past ID (ALUOp, ALUSrc, RegWEN, ...)
// PORTS
//  CLK            in   1      system clock, all state on rising edge
//  nRST           in   1      asynchronous reset, active low
//  ifid_en/ifid_flush, idex_en/idex_flush, exmem_en/exmem_flush, memwb_flush   in 1 each   hazard unit controls
//  if_instr       in   32     fetched instruction
//  if_npc         in   32     PC+4 of fetched instruction
//  ifid_instr     out  32     latched instruction; ifid_npc out 32 latched PC+4
//  ifid_rs        out  5      ifid_instr[25:21];  ifid_rt  out 5  ifid_instr[20:16]
//  id_data/id_ctrl         in   DATA_W/CTRL_W   decode-stage payload
//  id_wsel,id_dREN,id_dWEN,id_MemToReg,id_PCSrc,id_halt   in 5/1/1/3/3/1   decode control fields
//  idex_data/idex_ctrl/idex_wsel/idex_dREN/idex_dWEN/idex_MemToReg/idex_PCSrc/idex_halt   out   latched ID/EX fields, same widths
//  ex_data        in   DATA_W  execute-stage payload;  ex_ZeroFlag  in 1  ALU zero
//  exmem_data/exmem_ctrl/exmem_wsel/exmem_dREN/exmem_dWEN/exmem_MemToReg/exmem_PCSrc/exmem_ZeroFlag/exmem_halt   out   latched EX/MEM fields
//  mem_data       in   DATA_W  memory-stage payload (load data merged by MEM stage)
//  memwb_data/memwb_ctrl/memwb_wsel/memwb_dREN/memwb_MemToReg/memwb_halt   out   latched MEM/WB fields
//  halt           out  1      sticky CPU halt
//  retired        out  32     count of instructions retired through MEM/WB
// BEHAVIOUR
//  - Reset (nRST=0, async): every register, every output, halt latch and retired go to 0. A zeroed stage is a bubble.
//    instr=0 is sll $0 (a nop). wsel=0 never creates a hazard.
//  - Each stage X, per rising edge: if X_flush then X<=0; else if X_en then X<=upstream; else hold.
//    Flush has priority over enable. MEM/WB has no enable: it loads every cycle unless memwb_flush.
//  - Latency: 1 cycle per stage. An instruction presented at IF with all enables high appears at memwb_* 4 edges later.
//  - Each stage carries an internal valid bit. It is loaded as 1 from IF when ifid_en is high. Flush clears it.
//    The bit follows the stage's en/flush rule.
//  - Stall/bubble: ifid_en=0, idex_flush=1 on one edge holds IF/ID and inserts a zero bubble in ID/EX.
//    Downstream stages advance normally.
//  - Halt: when memwb_halt=1 and memwb valid=1, the halt latch sets on that edge and stays set until reset.
//    While halt=1, all four stages hold regardless of en/flush and retired stops counting.
//  - retired: increments by 1 on each edge where MEM/WB holds a valid entry, halt=0 and memwb_flush=0.
//    The counted entry is the one being passed on to WB. The counter wraps 0xFFFFFFFF->0.
//  - Simultaneous: flush and en both high on one stage -> flush. A flushed (invalid) halt never sets the halt latch.
//  - Reset mid-operation: all in-flight instructions are discarded immediately, with no partial commit.
//  - Outputs are pure register outputs, with no combinational path from inputs to outputs.
//    Exception: ifid_rs/ifid_rt are bit slices of the registered ifid_instr.
// TESTING
//  1 reset: nRST=0 while the pipe is full -> all outputs 0, retired=0, halt=0 asynchronously, before the next CLK edge.
//  2 flow: feed 4 instrs {0x8C220004,0x00221820,0xAC030008,0xFFFFFFFF(halt)} with all en=1, flush=0.
//    -> each appears at memwb 4 edges later; retired=3; halt=1 on the edge the halt is in memwb.
//  3 load-use stall: ifid_en=0, idex_flush=1 for 1 cycle -> ifid_instr unchanged; idex_wsel=0, idex_dREN=0 next cycle.
//    The bubble reaches memwb 2 edges later and is not counted in retired.
//  4 branch flush: ifid_flush=idex_flush=exmem_flush=1 with exmem_PCSrc=3'b001 on one edge.
//    -> next cycle ifid_instr=0, idex_*=0, exmem_*=0; retired counts only the older instr in memwb.
//  5 priority/dcache wait: idex_en=0, exmem_en=0 with memwb_flush=1 -> ID/EX and EX/MEM hold, MEM/WB zero.
//    idex_en=1 with idex_flush=1 -> ID/EX zero.
//  6 halt freeze: after halt=1, toggle all en/flush for 10 cycles -> every stage output and retired unchanged.

Source files
------------

// File: rtl/pipeline_stage_regs_if.sv
// pipeline_stage_regs_if: hazard controls, stage inputs and latched stage fields of the pipeline registers
interface pipeline_stage_regs_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);
    logic              ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush;
    logic [31:0]       if_instr, if_npc, ifid_instr, ifid_npc;
    logic [4:0]        ifid_rs, ifid_rt;
    logic [DATA_W-1:0] id_data, idex_data, ex_data, exmem_data, mem_data, memwb_data;
    logic [CTRL_W-1:0] id_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl;
    logic [4:0]        id_wsel, idex_wsel, exmem_wsel, memwb_wsel;
    logic              id_dREN, idex_dREN, exmem_dREN, memwb_dREN;
    logic              id_dWEN, idex_dWEN, exmem_dWEN;
    logic [2:0]        id_MemToReg, idex_MemToReg, exmem_MemToReg, memwb_MemToReg;
    logic [2:0]        id_PCSrc, idex_PCSrc, exmem_PCSrc;
    logic              id_halt, idex_halt, exmem_halt, memwb_halt;
    logic              ex_ZeroFlag, exmem_ZeroFlag;
    logic              halt;
    logic [31:0]       retired;

    modport master (
        output ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush,
               if_instr, if_npc, id_data, id_ctrl, id_wsel, id_dREN, id_dWEN, id_MemToReg,
               id_PCSrc, id_halt, ex_data, ex_ZeroFlag, mem_data,
        input  ifid_instr, ifid_npc, ifid_rs, ifid_rt,
               idex_data, idex_ctrl, idex_wsel, idex_dREN, idex_dWEN, idex_MemToReg, idex_PCSrc, idex_halt,
               exmem_data, exmem_ctrl, exmem_wsel, exmem_dREN, exmem_dWEN, exmem_MemToReg, exmem_PCSrc,
               exmem_ZeroFlag, exmem_halt,
               memwb_data, memwb_ctrl, memwb_wsel, memwb_dREN, memwb_MemToReg, memwb_halt,
               halt, retired
    );

    modport slave (
        input  ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush,
               if_instr, if_npc, id_data, id_ctrl, id_wsel, id_dREN, id_dWEN, id_MemToReg,
               id_PCSrc, id_halt, ex_data, ex_ZeroFlag, mem_data,
        output ifid_instr, ifid_npc, ifid_rs, ifid_rt,
               idex_data, idex_ctrl, idex_wsel, idex_dREN, idex_dWEN, idex_MemToReg, idex_PCSrc, idex_halt,
               exmem_data, exmem_ctrl, exmem_wsel, exmem_dREN, exmem_dWEN, exmem_MemToReg, exmem_PCSrc,
               exmem_ZeroFlag, exmem_halt,
               memwb_data, memwb_ctrl, memwb_wsel, memwb_dREN, memwb_MemToReg, memwb_halt,
               halt, retired
    );
endinterface

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: IF/ID, ID/EX, EX/MEM, MEM/WB registers with sticky halt and retired counter
module pipeline_stage_regs #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input logic                 CLK,
    input logic                 nRST,
    pipeline_stage_regs_if.slave bus
);
    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] npc;
    } ifid_t;
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        wsel;
        logic              dren, dwen;
        logic [2:0]        m2r, pcs;
        logic              hlt;
    } idex_t;
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        wsel;
        logic              dren, dwen;
        logic [2:0]        m2r, pcs;
        logic              zero, hlt;
    } exmem_t;
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        wsel;
        logic              dren;
        logic [2:0]        m2r;
        logic              hlt;
    } memwb_t;

    ifid_t       ifid;
    idex_t       idex;
    exmem_t      exmem;
    memwb_t      memwb;
    logic        halt;
    logic [31:0] retired;

    // IF/ID: flush beats enable; a loaded fetch is always a valid entry
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) ifid <= '0;
        else if (!halt) begin
            if (bus.ifid_flush) ifid <= '0;
            else if (bus.ifid_en) ifid <= {1'b1, bus.if_instr, bus.if_npc};
        end

    // ID/EX: decode fields, validity inherited from IF/ID
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) idex <= '0;
        else if (!halt) begin
            if (bus.idex_flush) idex <= '0;
            else if (bus.idex_en)
                idex <= {ifid.v, bus.id_data, bus.id_ctrl, bus.id_wsel, bus.id_dREN, bus.id_dWEN,
                         bus.id_MemToReg, bus.id_PCSrc, bus.id_halt};
        end

    // EX/MEM: ALU payload and zero flag replace the ID payload, control rides along
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) exmem <= '0;
        else if (!halt) begin
            if (bus.exmem_flush) exmem <= '0;
            else if (bus.exmem_en)
                exmem <= {idex.v, bus.ex_data, idex.ctrl, idex.wsel, idex.dren, idex.dwen,
                          idex.m2r, idex.pcs, bus.ex_ZeroFlag, idex.hlt};
        end

    // MEM/WB: no enable, loads every cycle unless flushed or halted
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) memwb <= '0;
        else if (!halt)
            memwb <= bus.memwb_flush ? '0 :
                     {exmem.v, bus.mem_data, exmem.ctrl, exmem.wsel, exmem.dren, exmem.m2r, exmem.hlt};

    // Halt latches on a valid halt leaving MEM/WB; other valid entries leaving MEM/WB retire
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            halt    <= 1'b0;
            retired <= '0;
        end else if (!halt) begin
            if (memwb.v && memwb.hlt) halt <= 1'b1;
            if (memwb.v && !memwb.hlt && !bus.memwb_flush) retired <= retired + 32'd1;
        end

    assign bus.ifid_instr     = ifid.instr;
    assign bus.ifid_npc       = ifid.npc;
    assign bus.ifid_rs        = ifid.instr[25:21];
    assign bus.ifid_rt        = ifid.instr[20:16];
    assign bus.idex_data      = idex.data;
    assign bus.idex_ctrl      = idex.ctrl;
    assign bus.idex_wsel      = idex.wsel;
    assign bus.idex_dREN      = idex.dren;
    assign bus.idex_dWEN      = idex.dwen;
    assign bus.idex_MemToReg  = idex.m2r;
    assign bus.idex_PCSrc     = idex.pcs;
    assign bus.idex_halt      = idex.hlt;
    assign bus.exmem_data     = exmem.data;
    assign bus.exmem_ctrl     = exmem.ctrl;
    assign bus.exmem_wsel     = exmem.wsel;
    assign bus.exmem_dREN     = exmem.dren;
    assign bus.exmem_dWEN     = exmem.dwen;
    assign bus.exmem_MemToReg = exmem.m2r;
    assign bus.exmem_PCSrc    = exmem.pcs;
    assign bus.exmem_ZeroFlag = exmem.zero;
    assign bus.exmem_halt     = exmem.hlt;
    assign bus.memwb_data     = memwb.data;
    assign bus.memwb_ctrl     = memwb.ctrl;
    assign bus.memwb_wsel     = memwb.wsel;
    assign bus.memwb_dREN     = memwb.dren;
    assign bus.memwb_MemToReg = memwb.m2r;
    assign bus.memwb_halt     = memwb.hlt;
    assign bus.halt           = halt;
    assign bus.retired        = retired;
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs: directed pipeline scenarios checked against an instruction-flow model
module tb_pipeline_stage_regs;
    localparam int DW = 96;
    localparam int CW = 8;
    localparam logic [6:0] NORM  = 7'b1010100;
    localparam logic [6:0] STALL = 7'b0011100;
    localparam logic [6:0] BR    = 7'b0101010;
    localparam logic [31:0] LW = 32'h8C220004, ADD = 32'h00221820, SW = 32'hAC030008;
    localparam logic [31:0] HLT = 32'hFFFFFFFF, BEQ = 32'h10220003, NOP2 = 32'h00000020;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    pipeline_stage_regs_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
    pipeline_stage_regs #(.DATA_W(DW), .CTRL_W(CW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct packed {
        logic          v;
        logic [31:0]   instr, npc;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [4:0]    wsel;
        logic          dren, dwen;
        logic [2:0]    m2r, pcs;
        logic          zero, hlt;
    } rec_t;

    rec_t        m0, m1, m2, m3;
    logic        m_halt;
    logic [31:0] m_ret, pc;
    int          errors = 0, checks = 0;
    bit          check_on = 1'b0;
    logic [5:0]  op;

    // A toy decoder/ALU/memory derived from the model's stage contents
    assign op              = m0.instr[31:26];
    assign bus.id_data     = {m0.instr, m0.npc, ~m0.instr};
    assign bus.id_ctrl     = m0.instr[31:24];
    assign bus.id_wsel     = op == 6'h00 ? m0.instr[15:11] : m0.instr[20:16];
    assign bus.id_dREN     = op == 6'h23;
    assign bus.id_dWEN     = op == 6'h2b;
    assign bus.id_MemToReg = {1'b0, op == 6'h23, op == 6'h00};
    assign bus.id_PCSrc    = op == 6'h04 ? 3'b001 : 3'b000;
    assign bus.id_halt     = m0.instr == 32'hFFFFFFFF;
    assign bus.ex_data     = m1.data + DW'(1);
    assign bus.ex_ZeroFlag = m1.wsel == 5'd0;
    assign bus.mem_data    = m2.data ^ {3{32'h5A5A5A5A}};

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m0 = '0; m1 = '0; m2 = '0; m3 = '0;
        m_halt = 1'b0;
        m_ret = '0;
    endtask

    task automatic model_step();
        rec_t n0, n1, n2, n3;
        if (m_halt) return;
        n0 = m0;
        if (bus.ifid_flush) n0 = '0;
        else if (bus.ifid_en) begin
            n0 = '0; n0.v = 1'b1; n0.instr = bus.if_instr; n0.npc = bus.if_npc;
        end
        n1 = m1;
        if (bus.idex_flush) n1 = '0;
        else if (bus.idex_en) begin
            n1 = '0; n1.v = m0.v; n1.data = bus.id_data; n1.ctrl = bus.id_ctrl; n1.wsel = bus.id_wsel;
            n1.dren = bus.id_dREN; n1.dwen = bus.id_dWEN; n1.m2r = bus.id_MemToReg;
            n1.pcs = bus.id_PCSrc; n1.hlt = bus.id_halt;
        end
        n2 = m2;
        if (bus.exmem_flush) n2 = '0;
        else if (bus.exmem_en) begin
            n2 = m1; n2.data = bus.ex_data; n2.zero = bus.ex_ZeroFlag;
        end
        n3 = m2; n3.data = bus.mem_data; n3.dwen = 1'b0; n3.pcs = '0; n3.zero = 1'b0;
        if (bus.memwb_flush) n3 = '0;
        if (m3.v && !m3.hlt && !bus.memwb_flush) m_ret = m_ret + 32'd1;
        if (m3.v && m3.hlt) m_halt = 1'b1;
        m0 = n0; m1 = n1; m2 = n2; m3 = n3;
    endtask

    task automatic compare();
        chk("ifid", {bus.ifid_instr, bus.ifid_npc}, {m0.instr, m0.npc});
        chk("ifid_rs_rt", {bus.ifid_rs, bus.ifid_rt}, {m0.instr[25:21], m0.instr[20:16]});
        chk("idex_data", bus.idex_data, m1.data);
        chk("idex_fields", {bus.idex_ctrl, bus.idex_wsel, bus.idex_dREN, bus.idex_dWEN, bus.idex_MemToReg,
                            bus.idex_PCSrc, bus.idex_halt},
                           {m1.ctrl, m1.wsel, m1.dren, m1.dwen, m1.m2r, m1.pcs, m1.hlt});
        chk("exmem_data", bus.exmem_data, m2.data);
        chk("exmem_fields", {bus.exmem_ctrl, bus.exmem_wsel, bus.exmem_dREN, bus.exmem_dWEN, bus.exmem_MemToReg,
                             bus.exmem_PCSrc, bus.exmem_ZeroFlag, bus.exmem_halt},
                            {m2.ctrl, m2.wsel, m2.dren, m2.dwen, m2.m2r, m2.pcs, m2.zero, m2.hlt});
        chk("memwb_data", bus.memwb_data, m3.data);
        chk("memwb_fields", {bus.memwb_ctrl, bus.memwb_wsel, bus.memwb_dREN, bus.memwb_MemToReg, bus.memwb_halt},
                            {m3.ctrl, m3.wsel, m3.dren, m3.m2r, m3.hlt});
        chk("halt", bus.halt, m_halt);
        chk("retired", bus.retired, m_ret);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) if (check_on && nRST) compare();

    task automatic ctl(input logic [6:0] c);
        {bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_flush} = c;
    endtask

    task automatic feed(input logic [31:0] ins);
        bus.if_instr = ins;
        bus.if_npc = pc;
        pc = pc + 32'd4;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        if (nRST) model_step();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        ctl(NORM);
        bus.if_instr = '0;
        bus.if_npc = '0;
        pc = 32'h0000_0004;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ctl(NORM);
        bus.if_instr = '0;
        bus.if_npc = '0;
        pc = '0;
        model_reset();
        do_reset();
        check_on = 1'b1;
        chk("reset_retired", bus.retired, 32'd0);
        chk("reset_ifid", bus.ifid_instr, 32'd0);

        // load-use stall
        feed(LW); cyc();
        feed(ADD); cyc();
        ctl(STALL); feed(SW); cyc();
        chk("stall_ifid_hold", bus.ifid_instr, ADD);
        chk("stall_idex_wsel", bus.idex_wsel, 5'd0);
        chk("stall_idex_dren", bus.idex_dREN, 1'b0);
        chk("stall_exmem_wsel", bus.exmem_wsel, 5'd2);
        ctl(NORM); cyc();
        feed(32'd0); cyc();
        chk("stall_ret_e5", bus.retired, 32'd1);
        cyc();
        chk("stall_ret_bubble", bus.retired, 32'd1);
        cyc();
        chk("stall_ret_e7", bus.retired, 32'd2);

        // branch flush with a halt sitting in IF/ID
        do_reset();
        feed(LW); cyc(); feed(BEQ); cyc(); feed(ADD); cyc(); feed(HLT); cyc();
        chk("br_exmem_pcsrc", bus.exmem_PCSrc, 3'b001);
        chk("br_memwb_wsel", bus.memwb_wsel, 5'd2);
        ctl(BR); feed(32'd0); cyc();
        chk("br_ifid_zero", bus.ifid_instr, 32'd0);
        chk("br_idex_zero", {bus.idex_wsel, bus.idex_halt, bus.idex_data}, '0);
        chk("br_exmem_zero", {bus.exmem_PCSrc, bus.exmem_wsel}, '0);
        chk("br_ret_e5", bus.retired, 32'd1);
        ctl(NORM); cyc();
        chk("br_ret_e6", bus.retired, 32'd2);
        repeat (3) cyc();
        chk("br_ret_e9", bus.retired, 32'd2);
        cyc();
        chk("br_ret_e10", bus.retired, 32'd3);
        chk("br_no_halt", bus.halt, 1'b0);

        // dcache wait and flush priority
        do_reset();
        feed(LW); cyc(); feed(ADD); cyc(); feed(SW); cyc(); feed(NOP2); cyc();
        ctl(7'b0000001); feed(32'd0); cyc();
        chk("pri_memwb_zero", {bus.memwb_wsel, bus.memwb_dREN}, '0);
        chk("pri_exmem_hold", bus.exmem_wsel, 5'd3);
        chk("pri_idex_hold", bus.idex_dWEN, 1'b1);
        chk("pri_ret", bus.retired, 32'd0);
        ctl(7'b1011100); cyc();
        chk("pri_idex_flush", {bus.idex_wsel, bus.idex_dWEN}, '0);
        chk("pri_exmem_load", {bus.exmem_wsel, bus.exmem_dWEN}, {5'd3, 1'b1});
        ctl(NORM); repeat (3) cyc();

        // flow to halt
        do_reset();
        feed(LW); cyc(); feed(ADD); cyc(); feed(SW); cyc(); feed(HLT); cyc();
        chk("flow_memwb_lw", {bus.memwb_wsel, bus.memwb_dREN}, {5'd2, 1'b1});
        feed(32'd0); repeat (3) cyc();
        chk("flow_memwb_halt", bus.memwb_halt, 1'b1);
        chk("flow_halt_pending", bus.halt, 1'b0);
        chk("flow_ret_e7", bus.retired, 32'd3);
        cyc();
        chk("flow_halt_set", bus.halt, 1'b1);
        chk("flow_ret_final", bus.retired, 32'd3);

        // halt freeze
        for (int i = 0; i < 10; i++) begin
            ctl(7'($urandom));
            feed($urandom);
            cyc();
        end
        chk("freeze_halt", bus.halt, 1'b1);
        chk("freeze_ret", bus.retired, 32'd3);

        // asynchronous reset mid-operation
        ctl(NORM);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("async_halt", bus.halt, 1'b0);
        chk("async_ret", bus.retired, 32'd0);
        chk("async_regs", {bus.ifid_instr, bus.idex_data, bus.exmem_wsel, bus.memwb_halt}, '0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        feed(ADD); cyc();
        feed(32'd0); repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
